// File: rtl/act_index_fetch.sv
// Read-side sequencer for the activation index RAM: fetches packed index words
// from a 1-cycle registered RAM and streams the unpacked indices over valid/ready.
module act_index_fetch #(
  parameter int DWIDTH = 56,
  parameter int AWIDTH = 7,
  parameter int IWIDTH = 7,
  parameter int SLOTS  = 8,
  parameter int CWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [CWIDTH-1:0] num_idx,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_q,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [IWIDTH-1:0] idx_data,
  output logic              idx_last,
  output logic [2:0]        state_dbg
);

  // Handshake: an index transfers on every rising clk edge where idx_valid and
  // idx_ready are both high; while idx_valid is high and idx_ready is low,
  // idx_data/idx_last hold and idx_valid stays high until the transfer.

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] SLOT_MAX = SW'(SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CAPT = 3'd2,
    S_STRM = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [CWIDTH-1:0]   rem_q, rem_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [DWIDTH-1:0]   word_q, word_d;
  logic                ce_q, ce_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [IWIDTH-1:0]   data_q, data_d;
  logic                last_q, last_d;

  function automatic logic [IWIDTH-1:0] unpack(input logic [DWIDTH-1:0] w,
                                               input logic [SW-1:0] s);
    logic [IWIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (s == SW'(k)) r = w[k*IWIDTH +: IWIDTH];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    slot_d  = slot_q;
    word_d  = word_q;
    ce_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_idx != '0) begin
            state_d = S_READ;
            addr_d  = base_addr;
            rem_d   = num_idx;
            ce_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_READ: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        // RAM data for the address issued in READ is valid this cycle.
        word_d  = ram_q;
        slot_d  = '0;
        valid_d = 1'b1;
        data_d  = ram_q[IWIDTH-1:0];
        last_d  = (rem_q == CWIDTH'(1));
        state_d = S_STRM;
      end
      S_STRM: begin
        if (valid_q && idx_ready) begin
          rem_d  = rem_q - CWIDTH'(1);
          slot_d = slot_q + SW'(1);
          if (rem_q == CWIDTH'(1)) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (slot_q == SLOT_MAX) begin
            // Word exhausted: fetch the next one, no prefetch.
            state_d = S_READ;
            addr_d  = addr_q + AWIDTH'(1);
            ce_d    = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            data_d = unpack(word_q, slot_q + SW'(1));
            last_d = (rem_q == CWIDTH'(2));
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      slot_q  <= '0;
      word_q  <= '0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      slot_q  <= slot_d;
      word_q  <= word_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_addr  = addr_q;
  assign ram_ce    = ce_q;
  assign ram_we    = 1'b0;
  assign idx_valid = valid_q;
  assign idx_data  = data_q;
  assign idx_last  = last_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_act_index_fetch.sv
// Bench for act_index_fetch: RAM model, reference stream built from the memory
// contents, directed jobs followed by randomized jobs with random backpressure.
module tb_act_index_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  base_addr = '0;
  logic [9:0]  num_idx = '0;
  logic        busy, done, ram_ce, ram_we;
  logic [6:0]  ram_addr;
  logic [55:0] ram_q = '0;
  logic        idx_valid, idx_last;
  logic        idx_ready = 1'b0;
  logic [6:0]  idx_data;
  logic [2:0]  state_dbg;

  act_index_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_idx(num_idx), .busy(busy), .done(done), .ram_addr(ram_addr),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_q(ram_q), .idx_valid(idx_valid),
    .idx_ready(idx_ready), .idx_data(idx_data), .idx_last(idx_last),
    .state_dbg(state_dbg)
  );

  // clock / reset / RAM model
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [55:0] mem [128];
  always @(posedge clk) if (ram_ce) ram_q <= mem[ram_addr];

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [6:0] exp_rd_q[$];
  logic [7:0] got_q[$];
  logic [6:0] rd_q[$];
  int done_cnt, done_cyc, first_ce_cyc, first_v_cyc, proto_err;
  int we_err = 0;
  logic done_busy;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [6:0] pd = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (ram_we !== 1'b0) we_err++;
      if (ram_ce) begin
        rd_q.push_back(ram_addr);
        if (first_ce_cyc < 0) first_ce_cyc = cyc;
      end
      if (idx_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (idx_valid && !busy) proto_err++;
      if (pv && !pr && (!idx_valid || idx_data !== pd || idx_last !== pl)) proto_err++;
      if (idx_valid && idx_ready) got_q.push_back({idx_last, idx_data});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_busy = busy;
      end
      pv = idx_valid; pr = idx_ready; pd = idx_data; pl = idx_last;
    end
  end

  // reference: index i of the job lives in word base+i/8, slot i%8, LSB first
  task automatic build_exp(input logic [6:0] b, input int n);
    logic [55:0] w;
    exp_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < n; i++) begin
      w = mem[b + 7'(i / 8)];
      exp_q.push_back({(i == n - 1), w[(i % 8) * 7 +: 7]});
    end
    for (int k = 0; k < (n + 7) / 8; k++) exp_rd_q.push_back(b + 7'(k));
  endtask

  task automatic clear_mon();
    got_q.delete();
    rd_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_ce_cyc = -1;
    first_v_cyc = -1;
    proto_err = 0;
    done_busy = 1'b1;
  endtask

  function automatic logic pick_ready(input int mode, input int t);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((t % 4) == 0) || ((t % 4) == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // driver: mode 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random
  task automatic run_job(input logic [6:0] b, input int n, input int mode, input string name);
    int c0;
    int nw;
    build_exp(b, n);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_idx = 10'(n); c0 = cyc;
    idx_ready = pick_ready(mode, 0);
    for (int t = 1; t < 4000 && done_cnt == 0; t++) begin
      @(posedge clk); #1;
      start = (t == 2 && n != 0);
      base_addr = 7'($urandom);
      num_idx = 10'($urandom);
      idx_ready = pick_ready(mode, t);
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nw = (n + 7) / 8;
    check({name, ".done_count"}, done_cnt, 1);
    check({name, ".busy_at_done"}, done_busy, 0);
    check({name, ".busy_idle"}, busy, 0);
    check({name, ".protocol"}, proto_err, 0);
    check({name, ".n_idx"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s.idx[%0d]", name, i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
    check({name, ".n_reads"}, rd_q.size(), exp_rd_q.size());
    for (int i = 0; i < exp_rd_q.size(); i++)
      check($sformatf("%s.rd[%0d]", name, i), (i < rd_q.size()) ? rd_q[i] : 7'hxx, exp_rd_q[i]);
    if (mode == 0) begin
      check({name, ".ce_cycle"}, first_ce_cyc, (n != 0) ? c0 + 1 : -1);
      check({name, ".valid_cycle"}, first_v_cyc, (n != 0) ? c0 + 3 : -1);
      check({name, ".done_cycle"}, done_cyc, c0 + 1 + 2 * nw + n);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".busy"}, busy, 0);
    check({name, ".done"}, done, 0);
    check({name, ".ram_addr"}, ram_addr, 0);
    check({name, ".ram_ce"}, ram_ce, 0);
    check({name, ".ram_we"}, ram_we, 0);
    check({name, ".idx_valid"}, idx_valid, 0);
    check({name, ".idx_data"}, idx_data, 0);
    check({name, ".idx_last"}, idx_last, 0);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) mem[a] = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 8; k++) mem[5][k*7 +: 7] = 7'(k + 1);

    // reset
    #2 rst_n = 1'b0;
    #10;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // directed jobs
    run_job(7'd5, 8, 0, "t1_one_word");
    check("t1.first_idx", exp_q[0], 8'h01);
    check("t1.last_idx", exp_q[7], 8'h88);
    run_job(7'd10, 19, 0, "t2_partial");
    run_job(7'd30, 21, 1, "t3_backpressure");
    run_job(7'd127, 16, 0, "t4_wrap");
    run_job(7'd40, 0, 0, "t5_zero");

    // abort mid-stream with reset, then a clean job
    build_exp(7'd20, 40);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 7'd20; num_idx = 10'd40; idx_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int t = 0; t < 100 && got_q.size() < 5; t++) begin
      @(posedge clk); #1;
    end
    check("t6.streaming", idx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6.no_done", done_cnt, 0);
    run_job(7'd60, 13, 0, "t6_after_rst");

    // randomized jobs
    for (int j = 0; j < 9; j++)
      run_job(7'($urandom), $urandom_range(1, 40), j % 3, $sformatf("rnd%0d", j));
    run_job(7'($urandom), 1023, 2, "big");
    check("ram_we_const", we_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
